seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Downstream consumer of the stopwatch BCD digit counter. Takes the eight 4-bit BCD
//  digits (ones = tenths of a second ... tenmillions) and time-multiplexes them onto
//  an 8-digit common-anode 7-segment display: refresh divider, digit pointer, frame
//  snapshot, segment decode, anti-ghost guard and decimal point. Runs on the board
//  system clock; the digit counter runs on its own 10 Hz clock.
// PARAMETERS
//  SCAN_DIV  100000  system-clock cycles per digit slot (>= GUARD+2)
//  GUARD     16      cycles at the start of each slot with all anodes off (>= 1)
// PORTS
//  clk               in   1  system clock, rising edge
//  rstN              in   1  asynchronous, active-low reset
//  ones              in   4  BCD digit 0 (tenths of a second), async to clk
//  tens..tenmillions in   4  BCD digits 1..7, one port each, same order as counter
//  an                out  8  anode enables, active-low; an[k] drives digit k
//  seg               out  7  segments active-low; seg[0]=a ... seg[6]=g
//  dp                out  1  decimal point, active-low
// BEHAVIOUR
//  - Reset (rstN=0, async): divCnt=0, ptr=0, shadow digits=0, an=8'hFF, seg=7'h7F,
//    dp=1. Outputs stay off until the first tick.
//  - divCnt counts 0..SCAN_DIV-1, wraps; tick = (divCnt==SCAN_DIV-1). First tick is
//    SCAN_DIV cycles after reset release.
//  - ptr (3-bit) = digit driven at the next tick; on tick ptr <= ptr+1, 7 wraps to 0.
//  - Frame snapshot: on a tick with ptr==0 all eight inputs are registered into the
//    shadow; digit 0 of that slot uses the freshly sampled value. Digits 1..7 always
//    come from shadow, so one frame never mixes two counter values (no tearing).
//    Inputs changing mid-frame take effect at the next ptr==0 tick only.
//  - On tick edge: seg <= decode(digit ptr), dp updated, an <= 8'hFF.
//  - GUARD cycles after the tick edge an[ptr_shown] goes low (one-hot-low), held until
//    the next tick edge. Never more than one anode low at any cycle.
//  - Decode (active-low, g..a): 0=7'h40 1=7'h79 2=7'h24 3=7'h30 4=7'h19 5=7'h12
//    6=7'h02 7=7'h78 8=7'h00 9=7'h10; codes 10..15 -> dash 7'h3F (g only).
//  - dp=0 in the slot of digit 1 (tens, "s.t" separator), dp=1 in all other slots.
//  - Slot order per frame: 0,1,...,7; frame period 8*SCAN_DIV cycles.
//  - Reset mid-slot: all outputs return to reset values immediately (async);
//    scan restarts from ptr=0 with a full SCAN_DIV wait.
//  - No handshake; inputs are assumed quasi-static (10 Hz) relative to clk; a
//    single-cycle sample at the snapshot tick is the only input timing point.
// CONFIGURATION
//  LZ_BLANK_EN defined: leading-zero blanking. At snapshot, digit k (k>=2) is marked
//    blank if it and every more-significant digit equal 0; a blank slot drives
//    seg=7'h7F, dp=1, and an=8'hFF for the whole slot. Digits 0 and 1 never blank,
//    so value 0 shows "0.0". Blank flags are part of the frame snapshot.
//  LZ_BLANK_EN undefined: all eight digits always shown, zeros included; no blank
//    flag registers are synthesized.
// TESTING (SCAN_DIV=4, GUARD=1 unless noted)
//  1 Reset: hold rstN=0 5 cycles -> an=FF, seg=7F, dp=1; after release outputs
//    unchanged for 4 cycles, then slot 0 begins (an=FF 1 cycle, then an=FE).
//  2 Scan order: digits 0..7 = 1..8 -> an steps FE,FD,FB,...,7F every 4 cycles with
//    seg 79,24,30,19,12,02,78,00; dp=0 only while digit 1 shown; wraps to FE.
//  3 Snapshot: set all digits 3, change all to 5 during slot 2 -> slots 2..7 still
//    show 7'h30; next frame every slot shows 7'h12.
//  4 Decode edge: ones=4'hA -> slot 0 seg=7'h3F; ones=9 -> 7'h10.
//  5 LZ_BLANK_EN: digits 7..0 = 0,0,0,1,0,0,0,7 -> slots 5..7 an=FF, seg=7F;
//    slots 2..4 show 7'h40,7'h40,7'h79; all-zero -> only slots 0,1 lit ("0.0").
//    Without macro: same stimulus lights all 8 slots.
//  6 Reset mid-slot 5: assert rstN=0 -> outputs to reset values same cycle; after
//    release scan resumes at slot 0 with fresh snapshot.

Source files
------------

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: BCD digit inputs and 7-segment display outputs of the scan driver
interface seg_scan_driver_if;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic [3:0] tenthousands;
    logic [3:0] hundredthousands;
    logic [3:0] millions;
    logic [3:0] tenmillions;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    modport master (
        output ones, tens, hundreds, thousands, tenthousands, hundredthousands, millions, tenmillions,
        input  an, seg, dp
    );
    modport slave (
        input  ones, tens, hundreds, thousands, tenthousands, hundredthousands, millions, tenmillions,
        output an, seg, dp
    );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit common-anode 7-segment scanner with frame snapshot, anti-ghost guard and dp; LZ_BLANK_EN adds leading-zero blanking
module seg_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 16
) (
    input  logic clk,
    input  logic rstN,
    seg_scan_driver_if.slave bus
);
    localparam int W = $clog2(SCAN_DIV);
    localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);
    localparam logic [W-1:0] GRD  = W'(GUARD - 1);

    logic [W-1:0] divCnt;
    logic [2:0]   ptr;
    logic [2:0]   shown;
    logic         live;
    logic [3:0]   shadow [0:7];
    logic [3:0]   inDig  [0:7];
    logic         tick;
    logic [3:0]   digit;
    logic         slotBlank;
    logic         shownBlank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    assign inDig = '{bus.ones, bus.tens, bus.hundreds, bus.thousands,
                     bus.tenthousands, bus.hundredthousands, bus.millions, bus.tenmillions};
    assign tick  = divCnt == LAST;
    // digit 0 is taken live at the snapshot tick so the frame starts with the fresh value
    assign digit = ptr == 3'd0 ? inDig[0] : shadow[ptr];

`ifdef LZ_BLANK_EN
    logic [7:0] blank;
    logic [7:0] inBlank;

    // a digit is leading-zero when it and every more-significant digit are zero; digits 0,1 always shown
    always_comb begin
        inBlank    = '0;
        inBlank[7] = inDig[7] == 4'd0;
        for (int k = 6; k >= 2; k--) inBlank[k] = inBlank[k+1] && inDig[k] == 4'd0;
    end

    assign slotBlank = ptr == 3'd0 ? 1'b0 : blank[ptr];

    // blank flags are captured with the frame snapshot; the shown slot's flag is held for its whole slot
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            blank      <= '0;
            shownBlank <= 1'b0;
        end else if (tick) begin
            shownBlank <= ptr == 3'd0 ? 1'b0 : blank[ptr];
            if (ptr == 3'd0) blank <= inBlank;
        end
    end
`else
    assign slotBlank  = 1'b0;
    assign shownBlank = 1'b0;
`endif

    // slot divider, digit pointer, frame snapshot and display outputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            divCnt <= '0;
            ptr    <= '0;
            shown  <= '0;
            live   <= 1'b0;
            shadow <= '{default: 4'd0};
            bus.an <= 8'hFF;
            bus.seg <= 7'h7F;
            bus.dp <= 1'b1;
        end else begin
            divCnt <= tick ? '0 : divCnt + 1'b1;
            if (tick) begin
                ptr     <= ptr + 3'd1;
                shown   <= ptr;
                live    <= 1'b1;
                bus.an  <= 8'hFF;
                bus.seg <= slotBlank ? 7'h7F : decode(digit);
                bus.dp  <= slotBlank || ptr != 3'd1;
                if (ptr == 3'd0) shadow <= inDig;
            end else if (live && !shownBlank && divCnt == GRD) begin
                bus.an <= ~(8'b1 << shown);
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver with SCAN_DIV=4, GUARD=1
module tb_seg_scan_driver;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    int   checks = 0;
    int   fails = 0;
    int   e = 0;
    logic [15:0] q [$];
    logic [7:0]  prevAn = 8'hFF;
    logic [6:0]  segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
`ifdef LZ_BLANK_EN
    localparam logic [7:0] SKIP_A = 8'hE0;
    localparam logic [7:0] SKIP_Z = 8'hFC;
    localparam logic [7:0] AN_A   = 8'hFF;
    localparam logic [7:0] AN_Z   = 8'hFF;
    localparam logic [6:0] SEG_B  = 7'h7F;
`else
    localparam logic [7:0] SKIP_A = 8'h00;
    localparam logic [7:0] SKIP_Z = 8'h00;
    localparam logic [7:0] AN_A   = 8'hBF;
    localparam logic [7:0] AN_Z   = 8'hF7;
    localparam logic [6:0] SEG_B  = 7'h40;
`endif

    seg_scan_driver_if bus ();
    seg_scan_driver #(.SCAN_DIV(4), .GUARD(1)) dut (.clk(clk), .rstN(rstN), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic chk_out(input string name, input logic [7:0] an, input logic [6:0] seg, input logic dp);
        chk({name, " an"}, {8'h00, bus.an}, {8'h00, an});
        chk({name, " seg"}, {9'h000, bus.seg}, {9'h000, seg});
        chk({name, " dp"}, {15'h0000, bus.dp}, {15'h0000, dp});
    endtask

    task automatic set_digs(input logic [31:0] v);
        {bus.tenmillions, bus.millions, bus.hundredthousands, bus.tenthousands,
         bus.thousands, bus.hundreds, bus.tens, bus.ones} = v;
    endtask

    task automatic push_frame(input logic [31:0] v, input logic [7:0] skip);
        for (int k = 0; k < 8; k++)
            if (!skip[k]) q.push_back({~(8'b1 << k), segTab[v[4*k +: 4]], k != 1});
    endtask

    task automatic go(input int t);
        while (e < t) begin
            @(posedge clk);
            e++;
        end
        #2;
    endtask

    // monitor: anode exclusivity every cycle, and each newly lit slot against the scoreboard
    always begin
        @(posedge clk);
        #1;
        chk("one anode", {15'h0000, $countones(~bus.an) > 1}, 16'h0000);
        if (bus.an != 8'hFF && prevAn == 8'hFF) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected slot: got an=%h seg=%h dp=%b, required no lit slot", bus.an, bus.seg, bus.dp);
            end else begin
                chk("slot", {bus.an, bus.seg, bus.dp}, q.pop_front());
            end
        end
        prevAn = bus.an;
    end

    initial begin
        set_digs(32'h87654321);
        repeat (5) @(posedge clk);
        #2;
        chk_out("reset", 8'hFF, 7'h7F, 1'b1);
        push_frame(32'h87654321, 8'h00);
        push_frame(32'h87654321, 8'h00);
        rstN = 1'b1;
        e = 0;
        go(3);
        chk_out("pre tick", 8'hFF, 7'h7F, 1'b1);
        go(4);
        chk_out("guard", 8'hFF, 7'h79, 1'b1);
        go(40);
        set_digs(32'h33333333);
        push_frame(32'h33333333, 8'h00);
        go(77);
        set_digs(32'h55555555);
        push_frame(32'h55555555, 8'h00);
        go(105);
        set_digs(32'h555555FA);
        push_frame(32'h555555FA, 8'h00);
        go(140);
        set_digs(32'h55555559);
        push_frame(32'h55555559, 8'h00);
        go(170);
        set_digs(32'h00010007);
        push_frame(32'h00010007, SKIP_A);
        push_frame(32'h00010007, SKIP_A);
        go(222);
        chk_out("lz slot6", AN_A, SEG_B, 1'b1);
        go(230);
        set_digs(32'h00000000);
        push_frame(32'h00000000, SKIP_Z);
        go(270);
        set_digs(32'h87654321);
        push_frame(32'h87654321, 8'hC0);
        go(274);
        chk_out("zero slot3", AN_Z, SEG_B, 1'b1);
        go(315);
        rstN = 1'b0;
        #1;
        chk_out("mid reset", 8'hFF, 7'h7F, 1'b1);
        set_digs(32'h1234567A);
        repeat (3) @(posedge clk);
        #2;
        push_frame(32'h1234567A, 8'h00);
        rstN = 1'b1;
        e = 0;
        go(4);
        chk_out("restart", 8'hFF, 7'h3F, 1'b1);
        go(34);
        chk("drained", 16'(q.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
